// File: rtl/key_repeat.sv
// Debounced push-button with press/release strobes, timed auto-repeat and a
// wrapping note index for a downstream tone divider.
module key_repeat #(
    parameter int SAMPLE_TIME = 500000,
    parameter int HOLD_TIME   = 25000000,
    parameter int REPEAT_TIME = 5000000,
    parameter int MAX_IDX     = 9
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic [3:0] note_idx,
    output logic [2:0] dbg_state
);

    localparam int MAX_T = (HOLD_TIME > REPEAT_TIME)
                         ? ((HOLD_TIME > SAMPLE_TIME) ? HOLD_TIME : SAMPLE_TIME)
                         : ((REPEAT_TIME > SAMPLE_TIME) ? REPEAT_TIME : SAMPLE_TIME);
    localparam int CW = ($clog2(MAX_T + 1) > 25) ? $clog2(MAX_T + 1) : 25;

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TIME - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TIME - 1);
    localparam logic [3:0]    MAX_NOTE    = 4'(MAX_IDX);

    typedef enum logic [2:0] {
        RELEASED    = 3'd0,
        PRESS_CHK   = 3'd1,
        HOLD        = 3'd2,
        REPEAT      = 3'd3,
        RELEASE_CHK = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_repeat;
    logic          r_release;
    logic [3:0]    r_note;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press_nxt;
    logic          w_repeat_nxt;
    logic          w_release_nxt;

    // Reset to the idle (released) level so a held key must requalify.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_repeat  <= w_repeat_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_press_nxt   = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (r_sync2) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (r_sync2) begin
                    w_state_nxt = RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt  = REPEAT;
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end
            end
            REPEAT: begin
                // The counter is reused as the inter-repeat period timer.
                if (r_sync2) begin
                    w_state_nxt = RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_nxt    = '0;
                    w_repeat_nxt = 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Out-of-range values also fold back to 0 on the next step.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_note <= 4'd0;
        end else if (r_press || r_repeat) begin
            r_note <= (r_note >= MAX_NOTE) ? 4'd0 : r_note + 4'd1;
        end
    end

    assign key_level     = (r_state == HOLD) || (r_state == REPEAT) ||
                           (r_state == RELEASE_CHK);
    assign press_pulse   = r_press;
    assign repeat_pulse  = r_repeat;
    assign release_pulse = r_release;
    assign note_idx      = r_note;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: directed table, glitch/reset sequences and random
// press patterns checked against an event-timestamp reference model.
module tb_key_repeat;

    localparam int S   = 4;
    localparam int H   = 10;
    localparam int R   = 3;
    localparam int MAX = 9;

    logic       clk;
    logic       arst;
    logic       key_n;
    logic       key_level;
    logic       press_pulse;
    logic       repeat_pulse;
    logic       release_pulse;
    logic [3:0] note_idx;
    logic [2:0] dbg_state;

    key_repeat #(
        .SAMPLE_TIME(S),
        .HOLD_TIME  (H),
        .REPEAT_TIME(R),
        .MAX_IDX    (MAX)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .key_n        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .note_idx     (note_idx),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset, run lengths, next repeat time.
    int k;
    bit hist_q[$];
    bit m_level;
    int lowrun;
    int highrun;
    int next_rep;
    int m_note;
    bit pend_inc;

    // Tallies of observed DUT behaviour for directed tests.
    int n_press, n_rep, n_rel, first_press, first_rep, n_level_low;

    typedef struct {
        int low_cycles;
        int press_cnt;
        int rep_cnt;
        int rel_cnt;
        int press_edge;
        int rep_edge;
        int note;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        k        = 0;
        m_level  = 1'b0;
        lowrun   = 0;
        highrun  = 0;
        next_rep = -1;
        m_note   = 0;
        pend_inc = 1'b0;
    endtask

    task automatic clr_tally();
        n_press     = 0;
        n_rep       = 0;
        n_rel       = 0;
        first_press = -1;
        first_rep   = -1;
        n_level_low = 0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit kn);
        bit s;
        bit e_press, e_rep, e_rel;
        key_n = kn;
        @(posedge clk);
        #1;
        s = (hist_q.size() >= 2) ? hist_q[0] : 1'b1;
        hist_q.push_back(kn);
        if (hist_q.size() > 2) void'(hist_q.pop_front());
        if (pend_inc) m_note = (m_note + 1) % (MAX + 1);
        e_press = 0; e_rep = 0; e_rel = 0;
        if (!m_level) begin
            if (!s) begin
                lowrun++;
                if (lowrun == S + 1) begin
                    e_press  = 1;
                    m_level  = 1;
                    lowrun   = 0;
                    highrun  = 0;
                    next_rep = k + H;
                end
            end else begin
                lowrun = 0;
            end
        end else begin
            if (s) begin
                highrun++;
                if (highrun == S + 1) begin
                    e_rel   = 1;
                    m_level = 0;
                    highrun = 0;
                    lowrun  = 0;
                end
            end else if (highrun > 0) begin
                highrun  = 0;
                next_rep = k + H;
            end else if (k == next_rep) begin
                e_rep    = 1;
                next_rep = k + R;
            end
        end
        pend_inc = e_press | e_rep;

        chk("key_level", int'(key_level), int'(m_level));
        chk("press_pulse", int'(press_pulse), int'(e_press));
        chk("repeat_pulse", int'(repeat_pulse), int'(e_rep));
        chk("release_pulse", int'(release_pulse), int'(e_rel));
        chk("note_idx", int'(note_idx), m_note);
        chk("pulse_onehot", int'((int'(press_pulse) + int'(repeat_pulse) + int'(release_pulse)) <= 1), 1);

        if (press_pulse) begin
            n_press++;
            if (first_press < 0) first_press = k;
        end
        if (repeat_pulse) begin
            n_rep++;
            if (first_rep < 0) first_rep = k;
        end
        if (release_pulse) n_rel++;
        if (!key_level) n_level_low++;
        k++;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic apply_reset(input int cycles);
        arst = 1'b1;
        #1;
        chk("rst_key_level", int'(key_level), 0);
        chk("rst_press", int'(press_pulse), 0);
        chk("rst_repeat", int'(repeat_pulse), 0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_note", int'(note_idx), 0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit lvl;
        int len;
        arst  = 1'b1;
        key_n = 1'b1;
        model_reset();
        clr_tally();

        tbl[0] = '{low_cycles: 3,  press_cnt: 0, rep_cnt: 0, rel_cnt: 0, press_edge: -1, rep_edge: -1, note: 0};
        tbl[1] = '{low_cycles: 4,  press_cnt: 0, rep_cnt: 0, rel_cnt: 0, press_edge: -1, rep_edge: -1, note: 0};
        tbl[2] = '{low_cycles: 5,  press_cnt: 1, rep_cnt: 0, rel_cnt: 1, press_edge: 6,  rep_edge: -1, note: 1};
        tbl[3] = '{low_cycles: 8,  press_cnt: 1, rep_cnt: 0, rel_cnt: 1, press_edge: 6,  rep_edge: -1, note: 1};
        tbl[4] = '{low_cycles: 14, press_cnt: 1, rep_cnt: 0, rel_cnt: 1, press_edge: 6,  rep_edge: -1, note: 1};
        tbl[5] = '{low_cycles: 15, press_cnt: 1, rep_cnt: 1, rel_cnt: 1, press_edge: 6,  rep_edge: 16, note: 2};
        tbl[6] = '{low_cycles: 19, press_cnt: 1, rep_cnt: 2, rel_cnt: 1, press_edge: 6,  rep_edge: 16, note: 3};
        tbl[7] = '{low_cycles: 40, press_cnt: 1, rep_cnt: 9, rel_cnt: 1, press_edge: 6,  rep_edge: 16, note: 0};

        @(negedge clk);
        apply_reset(2);

        for (int t = 0; t < 8; t++) begin
            apply_reset(1);
            clr_tally();
            for (int i = 0; i < tbl[t].low_cycles; i++) step(1'b0);
            for (int i = 0; i < 20; i++) step(1'b1);
            chk($sformatf("tbl%0d_press_cnt", t), n_press, tbl[t].press_cnt);
            chk($sformatf("tbl%0d_rep_cnt", t), n_rep, tbl[t].rep_cnt);
            chk($sformatf("tbl%0d_rel_cnt", t), n_rel, tbl[t].rel_cnt);
            chk($sformatf("tbl%0d_press_edge", t), first_press, tbl[t].press_edge);
            chk($sformatf("tbl%0d_rep_edge", t), first_rep, tbl[t].rep_edge);
            chk($sformatf("tbl%0d_note", t), int'(note_idx), tbl[t].note);
            chk($sformatf("tbl%0d_level", t), int'(key_level), 0);
        end

        // Two-cycle high glitch while held: hold timing restarts from glitch end.
        apply_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0);
        clr_tally();
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("glitch_release_cnt", n_rel, 0);
        chk("glitch_level_low", n_level_low, 0);
        chk("glitch_first_rep", first_rep, 24);

        // Reset in the middle of REPEAT with the key still held.
        apply_reset(1);
        for (int i = 0; i < 27; i++) step(1'b0);
        chk("mid_rep_note", int'(note_idx), 5);
        chk("mid_rep_level", int'(key_level), 1);
        apply_reset(2);
        clr_tally();
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("post_rst_press_edge", first_press, 6);
        chk("post_rst_note", int'(note_idx), 1);

        // Random press patterns, including short bounces and resets.
        lvl = 1'b0;
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 3));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step(lvl);
            lvl = ~lvl;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 SHALL provide parameter SAMPLE_TIME, default 500000, meaning consecutive stable synchronized samples required to accept a key level change.
REQ-002 SHALL provide parameter HOLD_TIME, default 25000000, meaning cycles from accepted press to the first auto-repeat.
REQ-003 SHALL provide parameter REPEAT_TIME, default 5000000, meaning cycles between later auto-repeats.
REQ-004 SHALL provide parameter MAX_IDX, default 9, meaning the highest note index before wrap.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-006 SHALL have port arst, input, 1, meaning the asynchronous active-high reset.
REQ-007 SHALL have port key_n, input, 1, meaning the raw asynchronous push-button (0 = pressed).
REQ-008 SHALL have port key_level, output, 1, meaning the debounced key state (1 = pressed).
REQ-009 SHALL have port press_pulse, output, 1, meaning a one-cycle strobe on an accepted press.
REQ-010 SHALL have port repeat_pulse, output, 1, meaning a one-cycle strobe on each auto-repeat.
REQ-011 SHALL have port release_pulse, output, 1, meaning a one-cycle strobe on an accepted release.
REQ-012 SHALL have port note_idx, output, 4, meaning the note selector for the downstream tone divider.

Function
REQ-013 SHALL synchronize key_n through two flops; all decisions use the second-flop value.
REQ-014 SHALL implement states RELEASED, PRESS_CHK, HOLD, REPEAT, RELEASE_CHK with one shared cycle counter of at least 25 bits, cleared on every state change.
REQ-015 In RELEASED, sync low -> PRESS_CHK.
REQ-016 In PRESS_CHK, sync high -> RELEASED with no pulse; SAMPLE_TIME consecutive low samples -> HOLD with press_pulse for one cycle.
REQ-017 In HOLD, sync high -> RELEASE_CHK; counter reaching HOLD_TIME -> REPEAT with repeat_pulse for one cycle.
REQ-018 In REPEAT, sync high -> RELEASE_CHK; otherwise repeat_pulse for one cycle every REPEAT_TIME cycles.
REQ-019 In RELEASE_CHK, SAMPLE_TIME consecutive high samples -> RELEASED with release_pulse for one cycle; any low sample -> HOLD with counter restarted and no pulse.
REQ-020 key_level SHALL be 1 exactly in HOLD, REPEAT and RELEASE_CHK.
REQ-021 note_idx SHALL increment by 1 in the cycle after each press_pulse or repeat_pulse, and wrap from MAX_IDX to 0.
REQ-022 If note_idx is ever above MAX_IDX, the next increment SHALL load 0.
REQ-023 At most one of press_pulse, repeat_pulse and release_pulse SHALL be high in any cycle.
REQ-024 From the first clk edge that samples key_n low, press_pulse SHALL assert SAMPLE_TIME+2 cycles later, provided the key stays low.

Reset
REQ-025 arst high SHALL immediately force RELEASED, clear the counter, set both synchronizer flops to 1 and clear all outputs including note_idx, independent of clk.
REQ-026 Reset asserted mid-press SHALL emit no pulse; after release of reset, a key still held low SHALL go through the full PRESS_CHK qualification.
REQ-027 The first decisions after arst deasserts SHALL be made on the first following clk edge.

Verification (SAMPLE_TIME=4, HOLD_TIME=10, REPEAT_TIME=3, MAX_IDX=9)
REQ-028 Hold key_n low for 3 cycles, then high -> no pulses, key_level stays 0, note_idx stays 0.
REQ-029 Hold key_n low for 8 cycles -> press_pulse once at cycle 6, key_level goes 1, note_idx becomes 1.
REQ-030 Hold key_n low for 40 cycles -> press at 6, repeats 10 cycles after the press and then every 3 cycles; note_idx counts 1,2,3,...
REQ-031 Press and repeat until note_idx=9, then one more repeat -> note_idx=0.
REQ-032 While held, apply a 2-cycle high glitch, then low -> no release_pulse, key_level stays 1, HOLD restarts and the repeat timing is measured from the glitch end.
REQ-033 Assert arst mid-REPEAT with note_idx=5 -> all outputs 0 immediately; with the key still held, press_pulse 6 cycles after arst deasserts and note_idx becomes 1.
